// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_pkg
//  Purpose  : Shared definitions for the serial carry-lookahead adder:
//             FSM state encodings and the default operand width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

   // Default operand width; must be even and at least 2.
   localparam int c_default_width = 16;

   typedef logic [1:0] state_t;

   localparam logic [1:0] c_idle = 2'b00;
   localparam logic [1:0] c_run  = 2'b01;
   localparam logic [1:0] c_done = 2'b10;

endpackage : serial_add_pkg
`default_nettype wire

// File: rtl/cla2_slice.sv
`default_nettype none
// ============================================================================
//  Module   : cla2_slice
//  Purpose  : Combinational 2-bit carry-lookahead adder slice.
//  Ports    : a[1:0], b[1:0] - operand bits
//             ci             - carry in
//             s[1:0]         - sum bits
//             c1             - carry into bit 1 (used for overflow)
//             co             - carry out of bit 1
//  Revision : 1.0 - initial release
// ============================================================================
module cla2_slice (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       ci,
   output logic [1:0] s,
   output logic       c1,
   output logic       co
);

   logic [1:0] w_g;
   logic [1:0] w_p;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Both carries are formed directly from generate/propagate terms.
   assign c1 = w_g[0] | (w_p[0] & ci);
   assign co = w_g[1] | (w_p[1] & c1);

   assign s[0] = w_p[0] ^ ci;
   assign s[1] = w_p[1] ^ c1;

endmodule : cla2_slice
`default_nettype wire

// File: rtl/serial_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_cla_adder
//  Purpose  : Adds two WIDTH-bit operands plus carry-in, two bits per clock,
//             using a single 2-bit carry-lookahead slice. A result takes
//             WIDTH/2 RUN cycles; back-to-back starts from DONE are accepted.
//  Ports    : clk   - clock, rising edge
//             rst   - asynchronous active-high reset
//             start - add request, sampled in IDLE or DONE only
//             a, b  - operands, captured on the accepting edge
//             cin   - carry in, captured on the accepting edge
//             sum   - result (a+b+cin) mod 2^WIDTH
//             cout  - carry out of the MSB
//             ovf   - signed overflow
//             busy  - high while the add is in progress
//             done  - one-cycle result-valid pulse
//  Revision : 1.0 - initial release
// ============================================================================
module serial_cla_adder
   import serial_add_pkg::*;
#(
   parameter int WIDTH = c_default_width
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy,
   output logic             done
);

   localparam int                 c_cnt_w     = $clog2(WIDTH / 2) + 1;
   localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH / 2 - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;
   logic [c_cnt_w-1:0] r_cnt;

   logic [1:0]         w_s;
   logic               w_c1;
   logic               w_c2;
   logic [WIDTH+1:0]   w_sum_cat;
   logic               w_accept;

   cla2_slice u_slice (
      .a  (r_a[1:0]),
      .b  (r_b[1:0]),
      .ci (r_carry),
      .s  (w_s),
      .c1 (w_c1),
      .co (w_c2)
   );

   // New slice bits enter at the MSB end; after WIDTH/2 shifts the first
   // slice computed has migrated down to bits [1:0]. Concatenation keeps the
   // shift legal for WIDTH=2.
   assign w_sum_cat = {w_s, r_sum};

   assign w_accept = start && ((r_state == c_idle) || (r_state == c_done));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            c_run: begin
               r_sum   <= w_sum_cat[WIDTH+1:2];
               r_a     <= r_a >> 2;
               r_b     <= r_b >> 2;
               r_carry <= w_c2;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == c_last_step) begin
                  // Final slice holds the MSB: c1 is the carry into it.
                  r_cout  <= w_c2;
                  r_ovf   <= w_c1 ^ w_c2;
                  r_state <= c_done;
               end
            end
            default: begin
               // IDLE and DONE behave identically apart from the done flag.
               if (w_accept) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
                  r_state <= c_run;
               end else begin
                  r_state <= c_idle;
               end
            end
         endcase
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;
   assign busy = (r_state == c_run);
   assign done = (r_state == c_done);

endmodule : serial_cla_adder
`default_nettype wire

// File: tb/tb_serial_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_cla_adder
//  Purpose  : Directed self-checking bench for serial_cla_adder (WIDTH=16).
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_cla_adder;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        busy;
   logic        done;

   int n_cmp;
   int n_fail;

   serial_cla_adder #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full add: accept edge, seven busy edges, done on edge 8, one-cycle pulse.
   task automatic run_add(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic [15:0] es, input logic ec, input logic eo);
      a = ta; b = tb_; cin = tc; start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_accept"}, 32'(busy), 32'd1);
      for (int k = 1; k < 8; k++) begin
         tick();
         check({tag, "_done_early"}, 32'(done), 32'd0);
      end
      tick();
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_off"}, 32'(busy), 32'd0);
      check({tag, "_sum"}, 32'(sum), 32'(es));
      check({tag, "_cout"}, 32'(cout), 32'(ec));
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
      tick();
      check({tag, "_done_1cyc"}, 32'(done), 32'd0);
      check({tag, "_sum_hold"}, 32'(sum), 32'(es));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      tick();
      tick();
      check("rst_sum",  32'(sum),  32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf",  32'(ovf),  32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();

      run_add("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_add("wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_add("posovf", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
      run_add("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

      // start pulse during RUN must be ignored.
      a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      a = 16'hFFFF; start = 1'b1;
      tick();
      start = 1'b0; a = 16'h0000;
      tick(); tick(); tick();
      check("ign_done_early", 32'(done), 32'd0);
      tick();
      check("ign_done", 32'(done), 32'd1);
      check("ign_sum",  32'(sum),  32'h0002);
      check("ign_cout", 32'(cout), 32'd0);
      tick();
      check("ign_busy_after", 32'(busy), 32'd0);
      check("ign_done_after", 32'(done), 32'd0);
      tick();

      // Back-to-back: start held during DONE.
      a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      check("b2b_first_done", 32'(done), 32'd1);
      check("b2b_first_sum",  32'(sum),  32'h5555);
      a = 16'h00FF; b = 16'h0F0F; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      check("b2b_busy_next", 32'(busy), 32'd1);
      check("b2b_no_done",   32'(done), 32'd0);
      for (int k = 0; k < 7; k++) tick();
      check("b2b_done_early", 32'(done), 32'd0);
      tick();
      check("b2b_done", 32'(done), 32'd1);
      check("b2b_sum",  32'(sum),  32'h100E);
      check("b2b_cout", 32'(cout), 32'd0);
      tick();

      // Asynchronous reset mid-operation.
      a = 16'h8000; b = 16'h8000; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick();
      check("ar_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("ar_sum",  32'(sum),  32'd0);
      check("ar_cout", 32'(cout), 32'd0);
      check("ar_ovf",  32'(ovf),  32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_done", 32'(done), 32'd0);
      tick();
      rst = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 10; k++) begin
            tick();
            if (done) seen++;
         end
         check("ar_no_done", 32'(seen), 32'd0);
      end
      run_add("after_rst", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_serial_cla_adder
`default_nettype wire

// File: doc/serial_cla_adder.md
SERIAL_CLA_ADDER -- requirements
Module: serial_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand width in bits; it SHALL be even and at least 2.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1, reset; it SHALL be asynchronous and active-high.
REQ-004 Port start, input, 1, request to add; it SHALL be sampled only in IDLE or DONE.
REQ-005 Port a, input, WIDTH, operand A; it SHALL be captured on the accepting edge.
REQ-006 Port b, input, WIDTH, operand B; it SHALL be captured on the accepting edge.
REQ-007 Port cin, input, 1, carry-in; it SHALL be captured on the accepting edge.
REQ-008 Port sum, output, WIDTH, registered result of a+b+cin.
REQ-009 Port cout, output, 1, registered carry out of bit WIDTH-1.
REQ-010 Port ovf, output, 1, registered signed overflow, equal to carry into bit WIDTH-1 XOR cout.
REQ-011 Port busy, output, 1, high while state is RUN.
REQ-012 Port done, output, 1, high for exactly one cycle while state is DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE with start=1, the edge SHALL do all of the following: capture a, b and cin into shift registers and the carry register; clear the step counter; enter RUN.
REQ-015 Each RUN edge SHALL add the two LSBs of both operand registers plus the carry register using a 2-bit carry-lookahead slice, with G=a&b, P=a^b, c1=G0|P0&c, c2=G1|P1&c1.
REQ-016 Each RUN edge SHALL shift the 2 slice sum bits into sum from the MSB end, shift both operand registers right by 2, load the carry register with c2, and increment the counter.
REQ-017 After WIDTH/2 RUN edges the FSM SHALL enter DONE; done SHALL be high in the cycle after the WIDTH/2-th edge, i.e. WIDTH/2 edges after the accepting edge (8 for WIDTH=16).
REQ-018 On the final RUN edge, cout SHALL load c2 and ovf SHALL load c1 XOR c2.
REQ-019 DONE with start=0 SHALL go to IDLE; sum, cout and ovf SHALL hold until the next accepted start.
REQ-020 DONE with start=1 SHALL accept the new operation immediately, so back-to-back adds have no idle gap.
REQ-021 start in RUN SHALL be ignored, and a, b and cin changes in RUN SHALL have no effect.
REQ-022 sum SHALL be the partially shifted value while busy and valid only while done is high or in IDLE after DONE.
REQ-023 The counter SHALL be clog2(WIDTH/2)+1 bits wide and SHALL never wrap within an operation.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH, with carry reported only on cout.

Reset
REQ-025 When rst=1, asynchronously: state SHALL be IDLE, and sum, cout, ovf, busy, done, the counter, the carry register and the operand registers SHALL all be 0.
REQ-026 rst mid-operation SHALL abort the add with no done pulse; the first start after release SHALL behave as in REQ-014.

Structure
REQ-027 A shared package/include, serial_add_pkg, SHALL hold the state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH.
REQ-028 The 2-bit lookahead logic SHALL be one combinational sub-module, cla2_slice, with ports a[1:0], b[1:0], ci, s[1:0], c1, co; it SHALL be instantiated once.
REQ-029 The FSM, counter and shift registers SHALL live in serial_cla_adder.

Verification
REQ-030 The bench SHALL drive a=0x1234, b=0x4321, cin=0 and start for 1 cycle, and SHALL check sum=0x5555, cout=0, ovf=0, with done high exactly 8 edges after acceptance, for 1 cycle.
REQ-031 The bench SHALL drive 0xFFFF+0x0001, cin=0, and SHALL check sum=0x0000, cout=1, ovf=0; then 0x7FFF+0x0000, cin=1, and SHALL check sum=0x8000, cout=0, ovf=1.
REQ-032 The bench SHALL drive 0x8000+0x8000, cin=0, and SHALL check sum=0x0000, cout=1, ovf=1.
REQ-033 The bench SHALL start 0x0001+0x0001, then at RUN cycle 3 pulse start with a=0xFFFF; it SHALL check result 0x0002, done at edge 8, and the second request ignored.
REQ-034 The bench SHALL hold start high in the DONE cycle with a=0x00FF, b=0x0F0F; it SHALL check busy rises next cycle and the second done shows sum=0x100E, cout=0, with no IDLE cycle between.
REQ-035 The bench SHALL assert rst at RUN cycle 4 of any add, and SHALL check all outputs 0 immediately (async), no done pulse, and a correct result on the next add.
